// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4-input data mux among four valid/ready
// requesters; multi-beat bursts lock the grant until the last beat.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-low reset
//   req_valid_i[3:0]     per-requester valid
//   req_last_i[3:0]      per-requester last-beat flag (sampled with the beat)
//   data0_i..data3_i     requester data
//   req_ready_o[3:0]     per-requester ready, one-hot or zero
//   select_o[1:0]        current grant index (shared mux select)
//   out_valid_o          output register holds a beat
//   out_data_o           registered beat data
//   out_src_o[1:0]       requester index of the registered beat
//   out_last_o           registered last flag
//   out_ready_i          consumer ready
module mux4_rr_arbiter #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [3:0]      req_valid_i,
    input  logic [3:0]      req_last_i,
    input  logic [size-1:0] data0_i,
    input  logic [size-1:0] data1_i,
    input  logic [size-1:0] data2_i,
    input  logic [size-1:0] data3_i,
    output logic [3:0]      req_ready_o,
    output logic [1:0]      select_o,
    output logic            out_valid_o,
    output logic [size-1:0] out_data_o,
    output logic [1:0]      out_src_o,
    output logic            out_last_o,
    input  logic            out_ready_i
);

    typedef enum logic {
        ARB,
        LOCKED
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      sel_q, sel_d;
    logic            out_valid_q, out_valid_d;
    logic [size-1:0] out_data_q, out_data_d;
    logic [1:0]      out_src_q, out_src_d;
    logic            out_last_q, out_last_d;

    logic            can_accept;
    logic [2:0]      rr_pick_w;
    logic [1:0]      grant;
    logic            grant_ok;
    logic [3:0]      ready;
    logic            xfer;
    logic [size-1:0] mux_data;

    // Returns {hit, index}: first valid requester scanning from p upward.
    // The loop runs from the farthest offset down so the nearest one wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] v,
                                           input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = {1'b0, p};
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (v[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

    assign can_accept = ~out_valid_q | out_ready_i;
    assign rr_pick_w  = rr_pick(req_valid_i, ptr_q);

    // With no request in ARB the select keeps its previous value.
    always_comb begin
        grant    = sel_q;
        grant_ok = 1'b0;
        if (state_q == LOCKED) begin
            grant    = owner_q;
            grant_ok = can_accept;
        end else if (rr_pick_w[2]) begin
            grant    = rr_pick_w[1:0];
            grant_ok = can_accept;
        end
        ready        = 4'b0000;
        ready[grant] = grant_ok;
        xfer         = grant_ok & req_valid_i[grant];
    end

    always_comb begin
        unique case (grant)
            2'd0:    mux_data = data0_i;
            2'd1:    mux_data = data1_i;
            2'd2:    mux_data = data2_i;
            default: mux_data = data3_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        sel_d       = grant;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_src_d   = grant;
            out_last_d  = req_last_i[grant];
            if (state_q == ARB) begin
                if (req_last_i[grant]) begin
                    ptr_d = grant + 2'd1;
                end else begin
                    state_d = LOCKED;
                    owner_d = grant;
                end
            end else if (req_last_i[grant]) begin
                state_d = ARB;
                ptr_d   = owner_q + 2'd1;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ARB;
            ptr_q       <= 2'd0;
            owner_q     <= 2'd0;
            sel_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
        end
    end

    // Combinational outputs are forced idle while reset is held.
    assign req_ready_o = rst_i ? ready : 4'b0000;
    assign select_o    = rst_i ? grant : 2'd0;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;
    assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: vector tables for ready/select,
// scoreboard queue for beats crossing into the output register.
module tb_mux4_rr_arbiter;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [3:0]   req_valid_i;
    logic [3:0]   req_last_i;
    logic [W-1:0] data0_i, data1_i, data2_i, data3_i;
    logic [3:0]   req_ready_o;
    logic [1:0]   select_o;
    logic         out_valid_o;
    logic [W-1:0] out_data_o;
    logic [1:0]   out_src_o;
    logic         out_last_o;
    logic         out_ready_i;

    mux4_rr_arbiter #(.size(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .data0_i     (data0_i),
        .data1_i     (data1_i),
        .data2_i     (data2_i),
        .data3_i     (data3_i),
        .req_ready_o (req_ready_o),
        .select_o    (select_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_src_o   (out_src_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       ordy;
        logic [3:0] rdy;
        logic [1:0] sel;
        logic       ovld;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   src;
        logic         last;
    } beat_t;

    beat_t       sb[$];
    beat_t       cur;
    int          checks = 0;
    int          errors = 0;
    logic [23:0] cnt[4];
    vec_t        tab_a[24];
    vec_t        tab_b[9];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l,
                                input logic o, input logic [3:0] r,
                                input logic [1:0] s, input logic ov);
        vec_t t;
        t.valid = v;
        t.last  = l;
        t.ordy  = o;
        t.rdy   = r;
        t.sel   = s;
        t.ovld  = ov;
        return t;
    endfunction

    function automatic logic [W-1:0] data_of(input logic [1:0] k);
        logic [7:0] tag;
        tag = 8'hA0 + {6'd0, k};
        return {cnt[k], tag};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_data();
        data0_i = data_of(2'd0);
        data1_i = data_of(2'd1);
        data2_i = data_of(2'd2);
        data3_i = data_of(2'd3);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic apply(input vec_t v, input string tag);
        logic [3:0] xf;
        beat_t      b;
        req_valid_i = v.valid;
        req_last_i  = v.last;
        out_ready_i = v.ordy;
        drive_data();
        #1;
        chk({tag, ".ready"}, 32'(req_ready_o), 32'(v.rdy));
        chk({tag, ".select"}, 32'(select_o), 32'(v.sel));
        xf = v.valid & v.rdy;
        if (xf != 4'b0000) begin
            b.data = data_of(v.sel);
            b.src  = v.sel;
            b.last = v.last[v.sel];
            sb.push_back(b);
        end
        @(posedge clk_i);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid_o), 32'(v.ovld));
        if (xf != 4'b0000) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s.scoreboard: got empty queue expected beat", tag);
            end else begin
                cur = sb.pop_front();
            end
            cnt[v.sel] = cnt[v.sel] + 24'd1;
        end
        if (v.ovld) begin
            chk({tag, ".data"}, out_data_o, cur.data);
            chk({tag, ".src"}, 32'(out_src_o), 32'(cur.src));
            chk({tag, ".last"}, 32'(out_last_o), 32'(cur.last));
        end
        @(negedge clk_i);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) cnt[k] = 24'd0;
        cur = '0;

        // fairness: all valid, single beats
        for (int i = 0; i < 8; i++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (i % 4);
            tab_a[i] = mk(4'hF, 4'hF, 1'b1, oh, 2'(i % 4), 1'b1);
        end
        // burst lock: req 2 holds the grant while req 0 waits
        tab_a[8]  = mk(4'b0010, 4'b0010, 1, 4'b0010, 2'd1, 1);
        tab_a[9]  = mk(4'b0101, 4'b0001, 1, 4'b0100, 2'd2, 1);
        tab_a[10] = mk(4'b0101, 4'b0001, 1, 4'b0100, 2'd2, 1);
        tab_a[11] = mk(4'b0101, 4'b0101, 1, 4'b0100, 2'd2, 1);
        tab_a[12] = mk(4'b0001, 4'b0001, 1, 4'b0001, 2'd0, 1);
        // backpressure
        tab_a[13] = mk(4'b0010, 4'b0010, 1, 4'b0010, 2'd1, 1);
        tab_a[14] = mk(4'b0010, 4'b0010, 0, 4'b0000, 2'd1, 1);
        tab_a[15] = mk(4'b0010, 4'b0010, 0, 4'b0000, 2'd1, 1);
        tab_a[16] = mk(4'b0010, 4'b0010, 0, 4'b0000, 2'd1, 1);
        tab_a[17] = mk(4'b0010, 4'b0010, 1, 4'b0010, 2'd1, 1);
        // idle hold, pointer wrap
        tab_a[18] = mk(4'b1000, 4'b1000, 1, 4'b1000, 2'd3, 1);
        tab_a[19] = mk(4'b0000, 4'b0000, 1, 4'b0000, 2'd3, 0);
        tab_a[20] = mk(4'b0000, 4'b0000, 0, 4'b0000, 2'd3, 0);
        tab_a[21] = mk(4'b0011, 4'b0011, 0, 4'b0001, 2'd0, 1);
        tab_a[22] = mk(4'b0010, 4'b0010, 1, 4'b0010, 2'd1, 1);
        tab_a[23] = mk(4'b0000, 4'b0000, 1, 4'b0000, 2'd1, 0);

        // after mid-burst reset, then LOCKED waiting on its owner
        tab_b[0] = mk(4'b1010, 4'b1010, 1, 4'b0010, 2'd1, 1);
        tab_b[1] = mk(4'b1000, 4'b1000, 1, 4'b1000, 2'd3, 1);
        tab_b[2] = mk(4'b0000, 4'b0000, 1, 4'b0000, 2'd3, 0);
        tab_b[3] = mk(4'b0100, 4'b0000, 1, 4'b0100, 2'd2, 1);
        tab_b[4] = mk(4'b1001, 4'b1001, 0, 4'b0000, 2'd2, 1);
        tab_b[5] = mk(4'b1001, 4'b1001, 1, 4'b0100, 2'd2, 0);
        tab_b[6] = mk(4'b1101, 4'b1101, 1, 4'b0100, 2'd2, 1);
        tab_b[7] = mk(4'b1001, 4'b1001, 1, 4'b1000, 2'd3, 1);
        tab_b[8] = mk(4'b0001, 4'b0001, 1, 4'b0001, 2'd0, 1);

        // reset with random inputs
        rst_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            req_valid_i = 4'($urandom);
            req_last_i  = 4'($urandom);
            out_ready_i = 1'($urandom);
            data0_i     = $urandom;
            data1_i     = $urandom;
            data2_i     = $urandom;
            data3_i     = $urandom;
        end
        #1;
        chk("rst.out_valid", 32'(out_valid_o), 32'd0);
        chk("rst.out_data", out_data_o, 32'd0);
        chk("rst.out_src", 32'(out_src_o), 32'd0);
        chk("rst.out_last", 32'(out_last_o), 32'd0);
        chk("rst.select", 32'(select_o), 32'd0);
        chk("rst.ready", 32'(req_ready_o), 32'd0);
        @(negedge clk_i);
        req_valid_i = 4'b0000;
        req_last_i  = 4'b0000;
        out_ready_i = 1'b1;
        rst_i       = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post_rst.out_valid", 32'(out_valid_o), 32'd0);
        chk("post_rst.select", 32'(select_o), 32'd0);
        chk("post_rst.ready", 32'(req_ready_o), 32'd0);
        @(negedge clk_i);

        for (int i = 0; i < 24; i++) begin
            apply(tab_a[i], $sformatf("a%0d", i));
        end

        // requester 1 locks, then reset lands mid-burst
        apply(mk(4'b0010, 4'b0000, 1, 4'b0010, 2'd1, 1), "rb0");
        rst_i = 1'b0;
        #1;
        chk("rb.out_valid", 32'(out_valid_o), 32'd0);
        chk("rb.out_data", out_data_o, 32'd0);
        chk("rb.ready", 32'(req_ready_o), 32'd0);
        chk("rb.select", 32'(select_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        sb.delete();

        for (int i = 0; i < 9; i++) begin
            apply(tab_b[i], $sformatf("b%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
